alu_writeback_sequencer: RTL and testbench

//  Sequences one ALU instruction (opcode 1000rfff): drives fctn_code to the ALU, waits for the

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/condition_code_register.sv | 35 +++
 rtl/alu_writeback_sequencer.sv | 134 +++++++++++++
 tb/tb_alu_writeback_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared state, opcode and destination encodings for the ALU writeback sequencer
package alu_seq_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t DECODE = 3'd1;
  localparam state_t SETTLE = 3'd2;
  localparam state_t WRITE  = 3'd3;
  localparam state_t DONE   = 3'd4;

  localparam logic [3:0] ALU_PREFIX = 4'b1000;

  localparam logic [2:0] FN_ADD  = 3'b000;
  localparam logic [2:0] FN_INC  = 3'b001;
  localparam logic [2:0] FN_AND  = 3'b010;
  localparam logic [2:0] FN_OR   = 3'b011;
  localparam logic [2:0] FN_XOR  = 3'b100;
  localparam logic [2:0] FN_NOT  = 3'b101;
  localparam logic [2:0] FN_SHL  = 3'b110;
  localparam logic [2:0] FN_NULL = 3'b111;

  localparam logic DEST_A = 1'b0;
  localparam logic DEST_D = 1'b1;

  // Only the adder-based functions produce a meaningful carry-out.
  function automatic logic carry_qualified(input logic [2:0] fctn);
    return (fctn == FN_ADD) || (fctn == FN_INC);
  endfunction

endpackage

// File: rtl/condition_code_register.sv
// rtl/condition_code_register.sv - zero/sign/carry flag flops with load enable and carry qualify
module condition_code_register (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic carry_qual_i,
  input  logic zero_i,
  input  logic sign_i,
  input  logic carry_i,
  output logic cc_zero_o,
  output logic cc_sign_o,
  output logic cc_carry_o
);

  logic zero_q;
  logic sign_q;
  logic carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
    end else if (load_i) begin
      zero_q  <= zero_i;
      sign_q  <= sign_i;
      carry_q <= carry_i & carry_qual_i;
    end
  end

  assign cc_zero_o  = zero_q;
  assign cc_sign_o  = sign_q;
  assign cc_carry_o = carry_q;

endmodule

// File: rtl/alu_writeback_sequencer.sv
// rtl/alu_writeback_sequencer.sv - sequences one ALU instruction and writes its result into A or D
module alu_writeback_sequencer
  import alu_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_sign,
  input  logic       alu_carry,
  output logic [2:0] fctn_code,
  output logic       alu_enable,
  input  logic       ext_load_a,
  input  logic       ext_load_d,
  input  logic [7:0] ext_data,
  output logic [7:0] a_reg,
  output logic [7:0] d_reg,
  output logic       cc_zero,
  output logic       cc_sign,
  output logic       cc_carry,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] fff_q, fff_d;
  logic       dest_q, dest_d;
  logic       illegal_q, illegal_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] fctn_q, fctn_d;
  logic [7:0] a_q, a_d;
  logic [7:0] d_q, d_d;
  logic       wr_en;

  assign wr_en = (state_q == WRITE) && (fff_q != FN_NULL);

  always_comb begin
    state_d   = state_q;
    fff_d     = fff_q;
    dest_d    = dest_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    fctn_d    = fctn_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          fff_d     = instr[2:0];
          dest_d    = instr[3];
          illegal_d = (instr[7:4] != ALU_PREFIX);
          state_d   = DECODE;
        end
      end
      DECODE: begin
        if (illegal_q) begin
          state_d = IDLE;
        end else begin
          fctn_d  = fff_q;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'd0) state_d = WRITE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // External loads go first so a same-cycle ALU write to that register overrides them.
  always_comb begin
    a_d = a_q;
    d_d = d_q;
    if (ext_load_a) a_d = ext_data;
    if (ext_load_d) d_d = ext_data;
    if (wr_en) begin
      if (dest_q == DEST_A) a_d = alu_result;
      else                  d_d = alu_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      fff_q     <= 3'd0;
      dest_q    <= DEST_A;
      illegal_q <= 1'b0;
      cnt_q     <= 4'd0;
      fctn_q    <= 3'd0;
      a_q       <= 8'd0;
      d_q       <= 8'd0;
    end else begin
      state_q   <= state_d;
      fff_q     <= fff_d;
      dest_q    <= dest_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
      fctn_q    <= fctn_d;
      a_q       <= a_d;
      d_q       <= d_d;
    end
  end

  condition_code_register u_ccr (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (wr_en),
    .carry_qual_i (carry_qualified(fff_q)),
    .zero_i       (alu_zero),
    .sign_i       (alu_sign),
    .carry_i      (alu_carry),
    .cc_zero_o    (cc_zero),
    .cc_sign_o    (cc_sign),
    .cc_carry_o   (cc_carry)
  );

  assign instr_ready = (state_q == IDLE);
  assign alu_enable  = (state_q == SETTLE) || (state_q == WRITE);
  assign done        = (state_q == DONE);
  assign err         = (state_q == DECODE) && illegal_q;
  assign fctn_code   = fctn_q;
  assign a_reg       = a_q;
  assign d_reg       = d_q;

endmodule

// File: tb/tb_alu_writeback_sequencer.sv
// tb/tb_alu_writeback_sequencer.sv - directed self-checking bench for alu_writeback_sequencer
module tb_alu_writeback_sequencer;

  logic       clk;
  logic       rst_n;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       alu_sign;
  logic       alu_carry;
  logic [2:0] fctn_code;
  logic       alu_enable;
  logic       ext_load_a;
  logic       ext_load_d;
  logic [7:0] ext_data;
  logic [7:0] a_reg;
  logic [7:0] d_reg;
  logic       cc_zero;
  logic       cc_sign;
  logic       cc_carry;
  logic       done;
  logic       err;

  int tests_run;
  int tests_failed;

  logic [31:0] done_v;
  logic [31:0] err_v;
  logic [31:0] rdy_v;
  logic [31:0] en_v;

  alu_writeback_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .alu_sign    (alu_sign),
    .alu_carry   (alu_carry),
    .fctn_code   (fctn_code),
    .alu_enable  (alu_enable),
    .ext_load_a  (ext_load_a),
    .ext_load_d  (ext_load_d),
    .ext_data    (ext_data),
    .a_reg       (a_reg),
    .d_reg       (d_reg),
    .cc_zero     (cc_zero),
    .cc_sign     (cc_sign),
    .cc_carry    (cc_carry),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_alu(input logic [7:0] res, input logic z, input logic s, input logic c);
    alu_result = res;
    alu_zero   = z;
    alu_sign   = s;
    alu_carry  = c;
  endtask

  // Presents ins in IDLE and returns just after the accepting edge.
  task automatic send(input logic [7:0] ins);
    @(negedge clk);
    instr       = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  // Samples outputs at the falling edge of cycles 1..n after the accept edge.
  task automatic observe(input int n);
    done_v = '0;
    err_v  = '0;
    rdy_v  = '0;
    en_v   = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      done_v[k] = done;
      err_v[k]  = err;
      rdy_v[k]  = instr_ready;
      en_v[k]   = alu_enable;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests_run++;
    if ({a_reg, d_reg} !== 16'h0000) begin
      $display("FAIL reset_regs a=%h d=%h expected 00 00", a_reg, d_reg); tests_failed++;
    end
    tests_run++;
    if ({cc_zero, cc_sign, cc_carry} !== 3'b000) begin
      $display("FAIL reset_flags zsc=%b expected 000", {cc_zero, cc_sign, cc_carry}); tests_failed++;
    end
    tests_run++;
    if ({instr_ready, alu_enable, done, err, fctn_code} !== 7'b1000000) begin
      $display("FAIL reset_ctrl rdy/en/done/err/fctn=%b expected 1000000",
               {instr_ready, alu_enable, done, err, fctn_code}); tests_failed++;
    end
  endtask

  task automatic test_ext_load_idle;
    @(negedge clk);
    ext_load_a = 1'b1;
    ext_data   = 8'h3C;
    @(negedge clk);
    ext_load_a = 1'b0;
    tests_run++;
    if ({a_reg, d_reg} !== 16'h3C00) begin
      $display("FAIL ext_load_idle a=%h d=%h expected 3c 00", a_reg, d_reg); tests_failed++;
    end
    tests_run++;
    if ({cc_zero, cc_sign, cc_carry} !== 3'b000) begin
      $display("FAIL ext_load_flags zsc=%b expected 000", {cc_zero, cc_sign, cc_carry}); tests_failed++;
    end
  endtask

  task automatic test_add_zero;
    set_alu(8'h00, 1'b1, 1'b0, 1'b1);
    send(8'h80);
    observe(6);
    tests_run++;
    if (done_v[6:1] !== 6'b010000) begin
      $display("FAIL add_done_latency done_by_cycle=%b expected 010000", done_v[6:1]); tests_failed++;
    end
    tests_run++;
    if (en_v[6:1] !== 6'b001110) begin
      $display("FAIL add_alu_enable en_by_cycle=%b expected 001110", en_v[6:1]); tests_failed++;
    end
    tests_run++;
    if (rdy_v[6:1] !== 6'b100000) begin
      $display("FAIL add_ready rdy_by_cycle=%b expected 100000", rdy_v[6:1]); tests_failed++;
    end
    tests_run++;
    if ({a_reg, d_reg, fctn_code} !== {8'h00, 8'h00, 3'b000}) begin
      $display("FAIL add_regs a=%h d=%h fctn=%b expected 00 00 000", a_reg, d_reg, fctn_code); tests_failed++;
    end
    tests_run++;
    if ({cc_zero, cc_sign, cc_carry} !== 3'b101) begin
      $display("FAIL add_flags zsc=%b expected 101", {cc_zero, cc_sign, cc_carry}); tests_failed++;
    end
  endtask

  task automatic test_and_carry_mask;
    set_alu(8'h81, 1'b0, 1'b1, 1'b1);
    send(8'h8A);
    observe(6);
    tests_run++;
    if ({a_reg, d_reg, fctn_code} !== {8'h00, 8'h81, 3'b010}) begin
      $display("FAIL and_regs a=%h d=%h fctn=%b expected 00 81 010", a_reg, d_reg, fctn_code); tests_failed++;
    end
    tests_run++;
    if ({cc_zero, cc_sign, cc_carry} !== 3'b010) begin
      $display("FAIL and_flags zsc=%b expected 010", {cc_zero, cc_sign, cc_carry}); tests_failed++;
    end
  endtask

  task automatic test_null;
    set_alu(8'h00, 1'b1, 1'b0, 1'b1);
    send(8'h81);
    observe(6);
    tests_run++;
    if ({cc_zero, cc_sign, cc_carry, a_reg} !== {3'b101, 8'h00}) begin
      $display("FAIL inc_preset zsc=%b a=%h expected 101 00", {cc_zero, cc_sign, cc_carry}, a_reg); tests_failed++;
    end
    set_alu(8'hFF, 1'b0, 1'b1, 1'b0);
    send(8'h87);
    observe(8);
    tests_run++;
    if (done_v[8:1] !== 8'b00010000) begin
      $display("FAIL null_done done_by_cycle=%b expected 00010000", done_v[8:1]); tests_failed++;
    end
    tests_run++;
    if ({a_reg, d_reg, fctn_code} !== {8'h00, 8'h81, 3'b111}) begin
      $display("FAIL null_regs a=%h d=%h fctn=%b expected 00 81 111", a_reg, d_reg, fctn_code); tests_failed++;
    end
    tests_run++;
    if ({cc_zero, cc_sign, cc_carry} !== 3'b101) begin
      $display("FAIL null_flags zsc=%b expected 101", {cc_zero, cc_sign, cc_carry}); tests_failed++;
    end
  endtask

  task automatic test_illegal;
    set_alu(8'hAA, 1'b0, 1'b1, 1'b1);
    send(8'h40);
    observe(8);
    tests_run++;
    if (err_v[8:1] !== 8'b00000001) begin
      $display("FAIL illegal_err err_by_cycle=%b expected 00000001", err_v[8:1]); tests_failed++;
    end
    tests_run++;
    if (done_v[8:1] !== 8'b00000000) begin
      $display("FAIL illegal_done done_by_cycle=%b expected 00000000", done_v[8:1]); tests_failed++;
    end
    tests_run++;
    if (rdy_v[2:1] !== 2'b10) begin
      $display("FAIL illegal_ready rdy_by_cycle=%b expected 10", rdy_v[2:1]); tests_failed++;
    end
    tests_run++;
    if ({a_reg, d_reg, fctn_code, cc_zero, cc_sign, cc_carry} !== {8'h00, 8'h81, 3'b111, 3'b101}) begin
      $display("FAIL illegal_state a=%h d=%h fctn=%b zsc=%b expected 00 81 111 101",
               a_reg, d_reg, fctn_code, {cc_zero, cc_sign, cc_carry}); tests_failed++;
    end
  endtask

  task automatic test_back_to_back;
    set_alu(8'h01, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    instr       = 8'h89;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    observe(12);
    instr_valid = 1'b0;
    tests_run++;
    if (done_v[12:1] !== 12'b010000010000) begin
      $display("FAIL b2b_done done_by_cycle=%b expected 010000010000", done_v[12:1]); tests_failed++;
    end
    tests_run++;
    if (rdy_v[12:1] !== 12'b100000100000) begin
      $display("FAIL b2b_ready rdy_by_cycle=%b expected 100000100000", rdy_v[12:1]); tests_failed++;
    end
    observe(6);
    tests_run++;
    if ({d_reg, cc_zero, cc_sign, cc_carry} !== {8'h01, 3'b001}) begin
      $display("FAIL b2b_result d=%h zsc=%b expected 01 001", d_reg, {cc_zero, cc_sign, cc_carry}); tests_failed++;
    end
  endtask

  task automatic test_ext_collision;
    set_alu(8'h0F, 1'b0, 1'b0, 1'b1);
    send(8'h80);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 4) begin
        ext_load_a = 1'b1;
        ext_load_d = 1'b1;
        ext_data   = 8'h55;
      end else begin
        ext_load_a = 1'b0;
        ext_load_d = 1'b0;
      end
    end
    tests_run++;
    if ({a_reg, d_reg} !== 16'h0F55) begin
      $display("FAIL ext_collision a=%h d=%h expected 0f 55", a_reg, d_reg); tests_failed++;
    end
    tests_run++;
    if ({cc_zero, cc_sign, cc_carry} !== 3'b001) begin
      $display("FAIL ext_collision_flags zsc=%b expected 001", {cc_zero, cc_sign, cc_carry}); tests_failed++;
    end
  endtask

  task automatic test_reset_mid_run;
    set_alu(8'h77, 1'b1, 1'b1, 1'b1);
    send(8'h8B);
    repeat (3) @(negedge clk);
    tests_run++;
    if (alu_enable !== 1'b1) begin
      $display("FAIL midrst_pre en=%b expected 1", alu_enable); tests_failed++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({a_reg, d_reg, fctn_code} !== {8'h00, 8'h00, 3'b000}) begin
      $display("FAIL midrst_regs a=%h d=%h fctn=%b expected 00 00 000", a_reg, d_reg, fctn_code); tests_failed++;
    end
    tests_run++;
    if ({instr_ready, alu_enable, cc_zero, cc_sign, cc_carry} !== 5'b10000) begin
      $display("FAIL midrst_ctrl rdy/en/zsc=%b expected 10000",
               {instr_ready, alu_enable, cc_zero, cc_sign, cc_carry}); tests_failed++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    observe(6);
    tests_run++;
    if ({done_v[6:1], rdy_v[6:1]} !== {6'b000000, 6'b111111}) begin
      $display("FAIL midrst_after done=%b rdy=%b expected 000000 111111", done_v[6:1], rdy_v[6:1]); tests_failed++;
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    instr        = 8'h00;
    instr_valid  = 1'b0;
    ext_load_a   = 1'b0;
    ext_load_d   = 1'b0;
    ext_data     = 8'h00;
    set_alu(8'h00, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    test_reset;
    test_ext_load_idle;
    test_add_zero;
    test_and_carry_mask;
    test_null;
    test_illegal;
    test_back_to_back;
    test_ext_collision;
    test_reset_mid_run;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
